// File: rtl/register_pipe_if.sv
// Handshake bundle for register_pipe: input push side, output pop side and control.
// The slave modport is the pipe's view; master is the producer/consumer environment.
interface register_pipe_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             enable;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] z;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport slave (
        input  enable,
        input  flush,
        input  d,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output z,
        output out_valid,
        output count
    );

    modport master (
        output enable,
        output flush,
        output d,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  z,
        input  out_valid,
        input  count
    );
endinterface

// File: rtl/register_pipe.sv
// Elastic register pipeline of DEPTH stages with valid/ready flow control,
// global enable freeze, synchronous flush and a registered occupancy count.
module register_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    register_pipe_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] stage_ready;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [CW-1:0]    count_q;
    logic             suffix_full;
    logic             push;
    logic             pop;

    // ready[i] = !valid[i] || ready[i+1] unrolled: a stage can load unless it
    // and every stage downstream of it are full while the consumer stalls.
    always_comb begin
        stage_ready = '0;
        suffix_full = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            suffix_full    = suffix_full && valid[i];
            stage_ready[i] = bus.out_ready || !suffix_full;
        end
    end

    always_comb begin
        src_valid    = '0;
        src_valid[0] = bus.in_valid;
        src_data[0]  = bus.d;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid[i-1];
            src_data[i]  = data[i-1];
        end
    end

    assign bus.in_ready  = bus.enable && !bus.flush && stage_ready[0];
    assign bus.out_valid = bus.enable && valid[DEPTH-1];
    assign bus.z         = data[DEPTH-1];
    assign bus.count     = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Data registers only capture real datums so bubbles leave stale data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (bus.enable) begin
            if (bus.flush) begin
                valid <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (stage_ready[i]) begin
                        valid[i] <= src_valid[i];
                        if (src_valid[i]) begin
                            data[i] <= src_data[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (bus.enable) begin
            if (bus.flush) begin
                count_q <= '0;
            end else begin
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_register_pipe.sv
// Scoreboard bench for register_pipe: DEPTH=4 and DEPTH=1 instances, directed vectors,
// negedge monitors popping expected data whenever an output transfer is presented.
module tb_register_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    register_pipe_if #(.WIDTH(32), .DEPTH(4)) b4 ();
    register_pipe_if #(.WIDTH(32), .DEPTH(1)) b1 ();

    register_pipe #(.WIDTH(32), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    register_pipe #(.WIDTH(32), .DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    int total = 0;
    int bad = 0;
    logic [31:0] q4 [$];
    logic [31:0] q1 [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic v, input logic [31:0] value);
        if (which == 4) begin
            b4.in_valid = v;
            b4.d        = value;
        end else begin
            b1.in_valid = v;
            b1.d        = value;
        end
    endtask

    task automatic drain4(input string name);
        for (int i = 0; i < 20 && b4.count != 0; i++) step();
        checkOutput({name, " count"}, 32'(b4.count), 0);
        checkOutput({name, " queue"}, q4.size(), 0);
    endtask

    // Output monitors: a transfer happens on the next edge whenever valid && ready here.
    always @(negedge clk) begin
        if (rst_n && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL d4 unexpected output: got %0d expected none", b4.z);
            end else begin
                checkOutput("d4 order", b4.z, q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL d1 unexpected output: got %0d expected none", b1.z);
            end else begin
                checkOutput("d1 order", b1.z, q1.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        b4.enable = 1'b1; b4.flush = 1'b0; b4.in_valid = 1'b0; b4.d = '0; b4.out_ready = 1'b1;
        b1.enable = 1'b1; b1.flush = 1'b0; b1.in_valid = 1'b0; b1.d = '0; b1.out_ready = 1'b1;

        #2;
        checkOutput("reset count", 32'(b4.count), 0);
        checkOutput("reset out_valid", 32'(b4.out_valid), 0);
        checkOutput("reset z", b4.z, 0);
        #10 rst_n = 1'b1;
        step();

        // Latency and ordering at full rate
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4, 1'b1, 32'(15 + 5 * i));
            q4.push_back(32'(15 + 5 * i));
            step();
        end
        applyStimulus(4, 1'b0, 0);
        checkOutput("latency out_valid", 32'(b4.out_valid), 1);
        checkOutput("latency z", b4.z, 15);
        for (int i = 1; i < 4; i++) begin
            step();
            checkOutput("stream z", b4.z, 32'(15 + 5 * i));
            checkOutput("stream out_valid", 32'(b4.out_valid), 1);
        end
        step();
        checkOutput("stream empty out_valid", 32'(b4.out_valid), 0);
        checkOutput("stream empty count", 32'(b4.count), 0);

        // Backpressure: 4 accepted, 5th refused
        b4.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4, 1'b1, 32'(41 + i));
            q4.push_back(32'(41 + i));
            #1;
            checkOutput("bp in_ready", 32'(b4.in_ready), 1);
            step();
        end
        applyStimulus(4, 1'b1, 45);
        #1;
        checkOutput("bp 5th in_ready", 32'(b4.in_ready), 0);
        step();
        checkOutput("bp full count", 32'(b4.count), 4);
        applyStimulus(4, 1'b0, 0);
        b4.out_ready = 1'b1;
        drain4("bp drain");

        // Enable freeze on a full pipe
        b4.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4, 1'b1, 32'(51 + i));
            q4.push_back(32'(51 + i));
            step();
        end
        applyStimulus(4, 1'b1, 77);
        b4.out_ready = 1'b1;
        b4.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("freeze out_valid", 32'(b4.out_valid), 0);
            checkOutput("freeze in_ready", 32'(b4.in_ready), 0);
            step();
            checkOutput("freeze count", 32'(b4.count), 4);
            checkOutput("freeze z", b4.z, 51);
        end
        applyStimulus(4, 1'b0, 0);
        b4.enable = 1'b1;
        drain4("freeze drain");

        // Flush beats a simultaneous push
        b4.out_ready = 1'b0;
        applyStimulus(4, 1'b1, 61);
        step();
        applyStimulus(4, 1'b1, 62);
        step();
        checkOutput("pre-flush count", 32'(b4.count), 2);
        b4.flush = 1'b1;
        b4.out_ready = 1'b1;
        applyStimulus(4, 1'b1, 99);
        #1;
        checkOutput("flush in_ready", 32'(b4.in_ready), 0);
        step();
        checkOutput("flush count", 32'(b4.count), 0);
        checkOutput("flush out_valid", 32'(b4.out_valid), 0);
        b4.flush = 1'b0;
        applyStimulus(4, 1'b0, 0);
        repeat (6) step();
        checkOutput("post-flush count", 32'(b4.count), 0);

        // Asynchronous reset with three stages occupied
        b4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4, 1'b1, 32'(71 + i));
            step();
        end
        applyStimulus(4, 1'b0, 0);
        checkOutput("pre-reset count", 32'(b4.count), 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset z", b4.z, 0);
        checkOutput("async reset out_valid", 32'(b4.out_valid), 0);
        checkOutput("async reset count", 32'(b4.count), 0);
        #1 rst_n = 1'b1;
        b4.out_ready = 1'b1;
        step();
        applyStimulus(4, 1'b1, 81);
        q4.push_back(81);
        step();
        applyStimulus(4, 1'b0, 0);
        step();
        step();
        step();
        checkOutput("post-reset out_valid", 32'(b4.out_valid), 1);
        checkOutput("post-reset z", b4.z, 81);
        step();
        checkOutput("final q4 empty", q4.size(), 0);

        // DEPTH=1 slice sustaining one transfer per cycle
        b1.out_ready = 1'b0;
        applyStimulus(1, 1'b1, 91);
        q1.push_back(91);
        step();
        checkOutput("d1 full count", 32'(b1.count), 1);
        b1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 32'(92 + i));
            q1.push_back(32'(92 + i));
            #1;
            checkOutput("d1 in_ready", 32'(b1.in_ready), 1);
            step();
            checkOutput("d1 count", 32'(b1.count), 1);
        end
        applyStimulus(1, 1'b0, 0);
        step();
        checkOutput("d1 drained count", 32'(b1.count), 0);
        checkOutput("d1 queue empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
